// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control unit with multi-cycle sequencing.
//   Decodes alu_op/funct into an extended ALU control code, flags undecoded
//   R-type functs, stretches MULT (and optionally DIV/DIVU) over a busy window,
//   and presents one result per accepted instruction via valid/ready.
// Optional feature macro: ALU_CTRL_DIV_EN (decodes div/divu as multi-cycle ops).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_ready       input handshake (alu_op, funct, shamt)
//   out_valid, out_ready     output handshake (alu_ctrl, shamt_out, illegal)
//   alu_ctrl  [CTRL_W-1:0]   decoded control, zero-extended
//   shamt_out [4:0]          shift amount, zero for non-shift ops
//   illegal                  R-type with undecoded funct
//   busy                     multi-cycle op in progress
module alu_ctrl_seq #(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [4:0]        shamt_out,
    output logic              illegal,
    output logic              busy
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, MULTI, HOLD} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [3:0]       dec_code;
    logic             dec_illegal;
    logic             dec_shift;
    logic             dec_multi;
    logic [CNT_W-1:0] dec_cnt;
    logic             accept;

    // Instruction decode; dec_cnt is the MULTI load value (N-1).
    always_comb begin
        dec_code    = 4'b0000;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        dec_multi   = 1'b0;
        dec_cnt     = '0;
        unique case (alu_op)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b11: dec_code = 4'b0001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: dec_code = 4'b0010;
                    6'b100010, 6'b100011: dec_code = 4'b0110;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b100110: dec_code = 4'b0011;
                    6'b100111: dec_code = 4'b1100;
                    6'b101010: dec_code = 4'b0111;
                    6'b101011: dec_code = 4'b1111;
                    6'b000000: begin dec_code = 4'b1000; dec_shift = 1'b1; end
                    6'b000010: begin dec_code = 4'b1001; dec_shift = 1'b1; end
                    6'b000011: begin dec_code = 4'b1010; dec_shift = 1'b1; end
                    6'b011000: begin
                        dec_code  = 4'b1101;
                        dec_multi = (MUL_CYCLES > 1);
                        dec_cnt   = CNT_W'(MUL_CYCLES - 1);
                    end
`ifdef ALU_CTRL_DIV_EN
                    6'b011010: begin
                        dec_code  = 4'b1110;
                        dec_multi = (DIV_CYCLES > 1);
                        dec_cnt   = CNT_W'(DIV_CYCLES - 1);
                    end
                    6'b011011: begin
                        dec_code  = 4'b1011;
                        dec_multi = (DIV_CYCLES > 1);
                        dec_cnt   = CNT_W'(DIV_CYCLES - 1);
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state; an accept (from IDLE or HOLD) always reloads the sequence.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (accept) begin
            if (dec_multi) begin
                state_n = MULTI;
                cnt_n   = dec_cnt;
            end else begin
                state_n = HOLD;
                cnt_n   = '0;
            end
        end else begin
            case (state)
                MULTI: begin
                    // Leaving as cnt reaches zero puts out_valid N cycles after accept.
                    if (cnt <= CNT_W'(1)) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                HOLD:    if (out_ready) state_n = IDLE;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
        out_valid = (state == HOLD);
        busy      = (state == MULTI);
    end

    // Result payload captured on accept, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl  <= '0;
            shamt_out <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            alu_ctrl  <= CTRL_W'(dec_code);
            shamt_out <= dec_shift ? shamt : 5'd0;
            illegal   <= dec_illegal;
        end
    end

endmodule
